// File: rtl/clock_time_keeper.sv
// clock_time_keeper: calendar clock with a 1 s prescaler, two debounced
// buttons (mode/up) and a field-setting FSM (RUN, SET_YEAR .. SET_MIN).
// The state register is exposed directly on field_sel for observation.
// Optional macro LEAP_YEAR_EN: February has 29 days when year[1:0]==0;
// without it February is always 28 days and no leap logic exists.
module clock_time_keeper #(
  parameter int CNT1S           = 100_000_000,
  parameter int DEBOUNCE_CYCLES = 2_000_000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        btn_mode,
  input  logic        btn_up,
  output logic [11:0] year,
  output logic [3:0]  month,
  output logic [4:0]  day,
  output logic [4:0]  hour,
  output logic [5:0]  min,
  output logic [5:0]  sec,
  output logic        set_mode,
  output logic [2:0]  field_sel,
  output logic        upd
);

  localparam int PW = (CNT1S > 1) ? $clog2(CNT1S) : 1;
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [2:0] {
    S_RUN   = 3'd0,
    S_YEAR  = 3'd1,
    S_MONTH = 3'd2,
    S_DAY   = 3'd3,
    S_HOUR  = 3'd4,
    S_MIN   = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [11:0]   year_q, year_d;
  logic [3:0]    month_q, month_d;
  logic [4:0]    day_q, day_d;
  logic [4:0]    hour_q, hour_d;
  logic [5:0]    min_q, min_d;
  logic [5:0]    sec_q, sec_d;
  logic          upd_q, upd_d;

  // Button front end, bit 0 = mode, bit 1 = up.
  logic [1:0]    btn_raw;
  logic [1:0]    sync1_q, sync2_q, db_q, db_prev_q;
  logic [DW-1:0] cnt_q [2];
  logic [1:0]    press;
  logic          mode_press, up_press;

  assign btn_raw    = {btn_up, btn_mode};
  assign press      = db_q & ~db_prev_q;
  assign mode_press = press[0];
  // A simultaneous mode press wins; the up press is dropped.
  assign up_press   = press[1] & ~press[0];

  // Synchronize raw buttons, then accept a new level only after DEBOUNCE_CYCLES equal samples.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      db_q      <= '0;
      db_prev_q <= '0;
      for (int b = 0; b < 2; b++) cnt_q[b] <= '0;
    end else begin
      sync1_q   <= btn_raw;
      sync2_q   <= sync1_q;
      db_prev_q <= db_q;
      for (int b = 0; b < 2; b++) begin
        if (sync2_q[b] == db_q[b]) begin
          cnt_q[b] <= '0;
        end else if (cnt_q[b] == DW'(DEBOUNCE_CYCLES - 1)) begin
          db_q[b]  <= sync2_q[b];
          cnt_q[b] <= '0;
        end else begin
          cnt_q[b] <= cnt_q[b] + 1'b1;
        end
      end
    end
  end

  function automatic logic [4:0] days_in(input logic [3:0] m, input logic [4:0] feb_len);
    case (m)
      4'd4, 4'd6, 4'd9, 4'd11: days_in = 5'd30;
      4'd2:                    days_in = feb_len;
      default:                 days_in = 5'd31;
    endcase
  endfunction

  logic        tick;
  logic [11:0] year_inc;
  logic [3:0]  month_inc;
  logic [4:0]  feb_cur, feb_year_inc;
  logic [4:0]  dim_cur, dim_month_inc, dim_year_inc;

  assign tick      = (presc_q == PW'(CNT1S - 1));
  assign year_inc  = (year_q == 12'd2099) ? 12'd2000 : year_q + 12'd1;
  assign month_inc = (month_q == 4'd12) ? 4'd1 : month_q + 4'd1;

`ifdef LEAP_YEAR_EN
  // Valid for 2000-2099: every multiple of four is a leap year.
  assign feb_cur      = (year_q[1:0] == 2'b00)   ? 5'd29 : 5'd28;
  assign feb_year_inc = (year_inc[1:0] == 2'b00) ? 5'd29 : 5'd28;
`else
  assign feb_cur      = 5'd28;
  assign feb_year_inc = 5'd28;
`endif

  assign dim_cur       = days_in(month_q, feb_cur);
  assign dim_month_inc = days_in(month_inc, feb_cur);
  assign dim_year_inc  = days_in(month_q, feb_year_inc);

  // Next-state: tick cascade in RUN, field edits and mode stepping in SET states.
  always_comb begin
    state_d = state_q;
    presc_d = tick ? '0 : presc_q + 1'b1;
    year_d  = year_q;
    month_d = month_q;
    day_d   = day_q;
    hour_d  = hour_q;
    min_d   = min_q;
    sec_d   = sec_q;
    case (state_q)
      S_RUN: begin
        if (tick) begin
          if (sec_q == 6'd59) begin
            sec_d = 6'd0;
            if (min_q == 6'd59) begin
              min_d = 6'd0;
              if (hour_q == 5'd23) begin
                hour_d = 5'd0;
                if (day_q >= dim_cur) begin
                  day_d = 5'd1;
                  month_d = month_inc;
                  if (month_q == 4'd12) year_d = year_inc;
                end else begin
                  day_d = day_q + 5'd1;
                end
              end else begin
                hour_d = hour_q + 5'd1;
              end
            end else begin
              min_d = min_q + 6'd1;
            end
          end else begin
            sec_d = sec_q + 6'd1;
          end
        end
        if (mode_press) state_d = S_YEAR;
      end
      S_YEAR: begin
        if (mode_press) begin
          state_d = S_MONTH;
        end else if (up_press) begin
          year_d = year_inc;
          if (day_q > dim_year_inc) day_d = dim_year_inc;
        end
      end
      S_MONTH: begin
        if (mode_press) begin
          state_d = S_DAY;
        end else if (up_press) begin
          month_d = month_inc;
          if (day_q > dim_month_inc) day_d = dim_month_inc;
        end
      end
      S_DAY: begin
        if (mode_press) state_d = S_HOUR;
        else if (up_press) day_d = (day_q >= dim_cur) ? 5'd1 : day_q + 5'd1;
      end
      S_HOUR: begin
        if (mode_press) state_d = S_MIN;
        else if (up_press) hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
      end
      S_MIN: begin
        if (mode_press) begin
          // Restart the second so the first tick lands a full CNT1S later.
          state_d = S_RUN;
          sec_d   = 6'd0;
          presc_d = '0;
        end else if (up_press) begin
          min_d = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
        end
      end
      default: state_d = S_RUN;
    endcase
    upd_d = (year_d != year_q) | (month_d != month_q) | (day_d != day_q) |
            (hour_d != hour_q) | (min_d != min_q) | (sec_d != sec_q);
  end

  // Register state, prescaler, time/date and the update strobe.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_RUN;
      presc_q <= '0;
      year_q  <= 12'd2024;
      month_q <= 4'd1;
      day_q   <= 5'd1;
      hour_q  <= 5'd0;
      min_q   <= 6'd0;
      sec_q   <= 6'd0;
      upd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      year_q  <= year_d;
      month_q <= month_d;
      day_q   <= day_d;
      hour_q  <= hour_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
      upd_q   <= upd_d;
    end
  end

  assign year      = year_q;
  assign month     = month_q;
  assign day       = day_q;
  assign hour      = hour_q;
  assign min       = min_q;
  assign sec       = sec_q;
  assign upd       = upd_q;
  assign set_mode  = (state_q != S_RUN);
  assign field_sel = state_q;

endmodule

// File: tb/tb_clock_time_keeper.sv
// Bench for clock_time_keeper with CNT1S=10, DEBOUNCE_CYCLES=4.
// A calendar model stepped on every rising edge is compared against the DUT
// on every falling edge; directed scenarios add literal date checks.
`timescale 1ns/1ps
module tb_clock_time_keeper;

  localparam int CNT1S = 10;
  localparam int DB    = 4;
`ifdef LEAP_YEAR_EN
  localparam bit LEAP_EN = 1'b1;
`else
  localparam bit LEAP_EN = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        btn_mode = 1'b0;
  logic        btn_up = 1'b0;
  logic [11:0] year;
  logic [3:0]  month;
  logic [4:0]  day;
  logic [4:0]  hour;
  logic [5:0]  min;
  logic [5:0]  sec;
  logic        set_mode;
  logic [2:0]  field_sel;
  logic        upd;

  always #5 clk = ~clk;

  clock_time_keeper #(.CNT1S(CNT1S), .DEBOUNCE_CYCLES(DB)) dut (
    .clk(clk), .resetn(resetn), .btn_mode(btn_mode), .btn_up(btn_up),
    .year(year), .month(month), .day(day), .hour(hour), .min(min), .sec(sec),
    .set_mode(set_mode), .field_sel(field_sel), .upd(upd)
  );

  // ---------------- scoreboard counters ----------------
  int checks = 0;
  int errors = 0;
  int upd_seen = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int     m_y, m_mo, m_d, m_h, m_mi, m_s, m_st;
  bit     m_upd;
  longint edge_k = 0;
  longint epoch = 0;
  int     s1[2], s2[2], lvl[2], nwin[2];
  int     win[2][DB];
  bit     pend[2];

  function automatic int dim(input int mo, input int y);
    if (mo == 2) return (LEAP_EN && (y % 4 == 0)) ? 29 : 28;
    if (mo == 4 || mo == 6 || mo == 9 || mo == 11) return 30;
    return 31;
  endfunction

  always @(posedge clk) begin : model_step
    int raw[2];
    bit pm, pu, tick, all_eq;
    int py, pmo, pd, ph, pmi, ps, smp;
    raw[0] = int'(btn_mode);
    raw[1] = int'(btn_up);
    edge_k++;
    if (!resetn) begin
      m_y = 2024; m_mo = 1; m_d = 1; m_h = 0; m_mi = 0; m_s = 0; m_st = 0;
      m_upd = 1'b0;
      epoch = edge_k;
      for (int b = 0; b < 2; b++) begin
        s1[b] = 0; s2[b] = 0; lvl[b] = 0; nwin[b] = 0; pend[b] = 1'b0;
      end
    end else begin
      pm = pend[0];
      pu = pend[1] && !pend[0];
      tick = (edge_k > epoch) && (((edge_k - epoch) % CNT1S) == 0);
      py = m_y; pmo = m_mo; pd = m_d; ph = m_h; pmi = m_mi; ps = m_s;
      if (m_st == 0) begin
        if (tick) begin
          m_s++;
          if (m_s == 60) begin m_s = 0; m_mi++; end
          if (m_mi == 60) begin m_mi = 0; m_h++; end
          if (m_h == 24) begin m_h = 0; m_d++; end
          if (m_d > dim(m_mo, m_y)) begin m_d = 1; m_mo++; end
          if (m_mo == 13) begin m_mo = 1; m_y++; end
          if (m_y == 2100) m_y = 2000;
        end
        if (pm) m_st = 1;
      end else if (pm) begin
        if (m_st == 5) begin
          m_st = 0; m_s = 0; epoch = edge_k;
        end else begin
          m_st++;
        end
      end else if (pu) begin
        case (m_st)
          1: m_y = (m_y == 2099) ? 2000 : m_y + 1;
          2: m_mo = m_mo % 12 + 1;
          3: m_d = (m_d >= dim(m_mo, m_y)) ? 1 : m_d + 1;
          4: m_h = (m_h + 1) % 24;
          default: m_mi = (m_mi + 1) % 60;
        endcase
        if (m_d > dim(m_mo, m_y)) m_d = dim(m_mo, m_y);
      end
      m_upd = (py != m_y) || (pmo != m_mo) || (pd != m_d) ||
              (ph != m_h) || (pmi != m_mi) || (ps != m_s);
      // Buttons: two-stage delay, then a level flips after DB equal samples.
      for (int b = 0; b < 2; b++) begin
        smp = s2[b];
        s2[b] = s1[b];
        s1[b] = raw[b];
        for (int j = DB - 1; j > 0; j--) win[b][j] = win[b][j-1];
        win[b][0] = smp;
        if (nwin[b] < DB) nwin[b]++;
        all_eq = (nwin[b] == DB);
        for (int j = 0; j < DB; j++) if (win[b][j] == lvl[b]) all_eq = 1'b0;
        pend[b] = 1'b0;
        if (all_eq) begin
          lvl[b] = 1 - lvl[b];
          pend[b] = (lvl[b] == 1);
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("year", 32'(year), 32'(m_y));
      chk("month", 32'(month), 32'(m_mo));
      chk("day", 32'(day), 32'(m_d));
      chk("hour", 32'(hour), 32'(m_h));
      chk("min", 32'(min), 32'(m_mi));
      chk("sec", 32'(sec), 32'(m_s));
      chk("set_mode", 32'(set_mode), 32'(m_st != 0));
      chk("field_sel", 32'(field_sel), 32'(m_st));
      chk("upd", 32'(upd), 32'(m_upd));
      if (upd === 1'b1) upd_seen++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic hold(input int m, input int u, input int hi, input int lo);
    @(negedge clk);
    btn_mode = m[0];
    btn_up = u[0];
    repeat (hi) @(negedge clk);
    btn_mode = 1'b0;
    btn_up = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic press_mode();
    hold(1, 0, 6, 8);
  endtask

  task automatic press_up();
    hold(0, 1, 6, 8);
  endtask

  // From RUN: walk every field to the target, then return to RUN.
  task automatic set_all(input int y, input int mo, input int d, input int h, input int mi);
    press_mode();
    repeat ((y - m_y + 100) % 100) press_up();
    press_mode();
    repeat ((mo - m_mo + 12) % 12) press_up();
    press_mode();
    repeat ((d - m_d + dim(m_mo, m_y)) % dim(m_mo, m_y)) press_up();
    press_mode();
    repeat ((h - m_h + 24) % 24) press_up();
    press_mode();
    repeat ((mi - m_mi + 60) % 60) press_up();
    press_mode();
  endtask

  task automatic wait_edge(input longint target);
    int budget = 5000;
    while (edge_k < target && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (edge_k < target) begin
      errors++;
      $display("FAIL wait_edge timeout edge=%0d target=%0d", edge_k, target);
    end
    #1;
  endtask

  task automatic chk_date(input string tag, input int y, input int mo, input int d,
                          input int h, input int mi, input int s);
    chk({tag, "_year"}, 32'(year), 32'(y));
    chk({tag, "_month"}, 32'(month), 32'(mo));
    chk({tag, "_day"}, 32'(day), 32'(d));
    chk({tag, "_hour"}, 32'(hour), 32'(h));
    chk({tag, "_min"}, 32'(min), 32'(mi));
    chk({tag, "_sec"}, 32'(sec), 32'(s));
  endtask

  // ---------------- stimulus ----------------
  initial begin : main
    int m0, h0;
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    chk_en = 1'b1;
    upd_seen = 0;
    #1;
    chk_date("reset", 2024, 1, 1, 0, 0, 0);
    chk("reset_field_sel", 32'(field_sel), 32'd0);
    chk("reset_upd", 32'(upd), 32'd0);

    // Sixty seconds from reset.
    wait_edge(epoch + 600);
    chk_date("run60", 2024, 1, 1, 0, 1, 0);
    chk("run60_upd_count", 32'(upd_seen), 32'd60);

    // Year rollover.
    set_all(2024, 12, 31, 23, 59);
    wait_edge(epoch + 600);
    chk_date("newyear", 2025, 1, 1, 0, 0, 0);

    // February end, with and without leap day.
    set_all(2024, 2, 28, 23, 59);
    wait_edge(epoch + 600);
    if (LEAP_EN) chk_date("feb", 2024, 2, 29, 0, 0, 0);
    else         chk_date("feb", 2024, 3, 1, 0, 0, 0);

    // Month change clamps day 31 down to February length.
    press_mode();
    press_mode();
    repeat ((1 - m_mo + 12) % 12) press_up();
    press_mode();
    repeat ((31 - m_d + 31) % 31) press_up();
    repeat (3) press_mode();
    press_mode();
    press_mode();
    chk("clamp_pre_day", 32'(day), 32'd31);
    chk("clamp_pre_sel", 32'(field_sel), 32'd2);
    upd_seen = 0;
    press_up();
    #1;
    chk("clamp_month", 32'(month), 32'd2);
    chk("clamp_day", 32'(day), LEAP_EN ? 32'd29 : 32'd28);
    chk("clamp_upd_count", 32'(upd_seen), 32'd1);

    // Glitch rejection and a clean press in SET_MIN.
    repeat (3) press_mode();
    chk("glitch_sel", 32'(field_sel), 32'd5);
    m0 = m_mi;
    hold(0, 1, 3, 10);
    #1;
    chk("glitch_min", 32'(min), 32'(m0));
    upd_seen = 0;
    hold(0, 1, 6, 10);
    #1;
    chk("press_min", 32'(min), 32'((m0 + 1) % 60));
    chk("press_upd_count", 32'(upd_seen), 32'd1);

    // Simultaneous mode+up in SET_HOUR: mode wins.
    repeat (5) press_mode();
    chk("both_pre_sel", 32'(field_sel), 32'd4);
    h0 = m_h;
    hold(1, 1, 6, 8);
    #1;
    chk("both_sel", 32'(field_sel), 32'd5);
    chk("both_hour", 32'(hour), 32'(h0));

    // Reset in the middle of SET_DAY.
    repeat (4) press_mode();
    press_up();
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    #1;
    chk_date("midset_reset", 2024, 1, 1, 0, 0, 0);
    chk("midset_set_mode", 32'(set_mode), 32'd0);
    chk("midset_field_sel", 32'(field_sel), 32'd0);
    chk("midset_upd", 32'(upd), 32'd0);

    // Random button activity with occasional resets.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
      end else begin
        hold(int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
             int'($urandom_range(1, 8)), int'($urandom_range(1, 8)));
      end
    end
    repeat (20) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/clock_time_keeper.md
CLOCK_TIME_KEEPER -- requirements
Module: clock_time_keeper

Interface
REQ-001 SHALL have parameter CNT1S, default 100_000_000, meaning clk cycles per 1 s tick.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 2_000_000, meaning consecutive stable cycles needed to accept a button level.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-004 SHALL have port resetn, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port btn_mode, input, 1 bit: raw asynchronous button that steps the set-mode field.
REQ-006 SHALL have port btn_up, input, 1 bit: raw asynchronous button that increments the selected field.
REQ-007 SHALL have output ports year [11:0], month [3:0], day [4:0], hour [4:0], min [5:0] and sec [5:0], all registered binary calendar/time values for the LCD display stage.
REQ-008 SHALL have port set_mode, output, 1 bit: 1 while any field is being set.
REQ-009 SHALL have port field_sel, output, 3 bits: 0=RUN, 1=year, 2=month, 3=day, 4=hour, 5=min.
REQ-010 SHALL have port upd, output, 1 bit: one-cycle pulse in the same cycle that any time/date output takes a new value.

Function
REQ-011 SHALL use a prescaler counting 0..CNT1S-1 that emits a one-cycle tick on its terminal count, then wraps to 0.
REQ-012 SHALL pass each button through a 2-flop synchronizer and then a debouncer; the debounced level changes only after DEBOUNCE_CYCLES consecutive identical synchronized samples.
REQ-013 SHALL generate a one-cycle press pulse on each 0->1 edge of a debounced level; holding a button gives no repeat.
REQ-014 SHALL implement FSM states RUN, SET_YEAR, SET_MONTH, SET_DAY, SET_HOUR and SET_MIN; each mode press advances one state in that order, and SET_MIN wraps to RUN.
REQ-015 SHALL, in RUN, advance sec on each tick and cascade rollovers: sec 59->0 carries to min, min 59->0 carries to hour, hour 23->0 carries to day, day max->1 carries to month, month 12->1 carries to year, and year 2099->2000.
REQ-016 SHALL use 31 days for months 1,3,5,7,8,10,12, 30 days for months 4,6,9,11, and 28 days for month 2 (see REQ-025).
REQ-017 SHALL ignore ticks in all SET states; time is frozen.
REQ-018 SHALL, on an up press in a SET state, increment only the selected field with wrap: year 2099->2000, month 12->1, day max->1, hour 23->0, min 59->0.
REQ-019 SHALL, when a year or month change makes day exceed the new month length, clamp day to that length in the same cycle.
REQ-020 SHALL, on the SET_MIN->RUN transition, clear sec and the prescaler to 0, so the first tick comes CNT1S cycles later.
REQ-021 SHALL give precedence to the mode press when mode and up presses occur in the same cycle; the up press is discarded.
REQ-022 SHALL drive set_mode = (state != RUN) and field_sel from the registered state, with zero combinational paths from inputs to outputs.

Reset
REQ-023 SHALL, when resetn=0 is sampled at a clk edge, set year=2024, month=1, day=1, hour=0, min=0, sec=0, state=RUN, set_mode=0, field_sel=0, upd=0, and clear the prescaler, synchronizers, debounce counters and debounced levels to 0.
REQ-024 SHALL abort any set operation when reset is asserted mid-set and return to the REQ-023 values without preserving any edited fields.

Configuration
REQ-025 SHALL support the macro LEAP_YEAR_EN: when defined, February has 29 days if year[1:0]==0 (valid for 2000-2099), for both rollover and clamping; when undefined, February always has 28 days and no leap logic is synthesized.

Verification
Bench parameters: CNT1S=10, DEBOUNCE_CYCLES=4.
REQ-026 SHALL verify: reset, then 60 ticks -> 2024/01/01 00:01:00, with exactly 60 upd pulses.
REQ-027 SHALL verify: set 2024/12/31 23:59 via buttons, exit to RUN, wait 60 ticks -> 2025/01/01 00:00:00.
REQ-028 SHALL verify: set 2024/02/28 23:59, wait 60 ticks -> 2024/02/29 with LEAP_YEAR_EN defined, or 2024/03/01 without it.
REQ-029 SHALL verify: day=31, month=1 in SET_MONTH, one up press -> month=2 and day=29 (LEAP_YEAR_EN) or 28 (without) in the same cycle, with one upd pulse.
REQ-030 SHALL verify: in SET_MIN, a 3-cycle btn_up glitch -> min unchanged; a 6-cycle stable press -> min+1 exactly once.
REQ-031 SHALL verify: mode and up presses in the same cycle while in SET_HOUR -> state=SET_MIN and hour unchanged; resetn low during SET_DAY -> REQ-023 values on the next edge.
